// File: rtl/bp_me_bank_steer_if.sv
// BedRock mem cmd/resp stream plus per-bank cache-slice ports.
// The steering stage takes the slave side; the core and the banks sit on the master side.
interface bp_me_bank_steer_if #(
    parameter int banks_p        = 2,
    parameter int header_width_p = 128,
    parameter int data_width_p   = 64
);
    logic [header_width_p-1:0]         cmd_header_i;
    logic [data_width_p-1:0]           cmd_data_i;
    logic                              cmd_v_i;
    logic                              cmd_last_i;
    logic                              cmd_ready_and_o;
    logic [header_width_p-1:0]         resp_header_o;
    logic [data_width_p-1:0]           resp_data_o;
    logic                              resp_v_o;
    logic                              resp_last_o;
    logic                              resp_ready_and_i;
    logic [banks_p*header_width_p-1:0] bank_cmd_header_o;
    logic [banks_p*data_width_p-1:0]   bank_cmd_data_o;
    logic [banks_p-1:0]                bank_cmd_v_o;
    logic [banks_p-1:0]                bank_cmd_last_o;
    logic [banks_p-1:0]                bank_cmd_ready_and_i;
    logic [banks_p*header_width_p-1:0] bank_resp_header_i;
    logic [banks_p*data_width_p-1:0]   bank_resp_data_i;
    logic [banks_p-1:0]                bank_resp_v_i;
    logic [banks_p-1:0]                bank_resp_last_i;
    logic [banks_p-1:0]                bank_resp_ready_and_o;

    modport slave (
        input  cmd_header_i, cmd_data_i, cmd_v_i, cmd_last_i,
        output cmd_ready_and_o,
        output resp_header_o, resp_data_o, resp_v_o, resp_last_o,
        input  resp_ready_and_i,
        output bank_cmd_header_o, bank_cmd_data_o,
        output bank_cmd_v_o, bank_cmd_last_o,
        input  bank_cmd_ready_and_i,
        input  bank_resp_header_i, bank_resp_data_i,
        input  bank_resp_v_i, bank_resp_last_i,
        output bank_resp_ready_and_o
    );

    modport master (
        output cmd_header_i, cmd_data_i, cmd_v_i, cmd_last_i,
        input  cmd_ready_and_o,
        input  resp_header_o, resp_data_o, resp_v_o, resp_last_o,
        output resp_ready_and_i,
        input  bank_cmd_header_o, bank_cmd_data_o,
        input  bank_cmd_v_o, bank_cmd_last_o,
        output bank_cmd_ready_and_i,
        output bank_resp_header_i, bank_resp_data_i,
        output bank_resp_v_i, bank_resp_last_i,
        input  bank_resp_ready_and_o
    );
endinterface

// File: rtl/bp_me_bank_steer.sv
// N-bank steering of one BedRock mem stream onto cache slices.
// Responses are merged back in issue order via a FIFO of bank indices.
module bp_me_bank_steer #(
    parameter int banks_p           = 2,
    parameter int header_width_p    = 128,
    parameter int data_width_p      = 64,
    parameter int addr_offset_p     = 0,
    parameter int paddr_width_p     = 40,
    parameter int bank_lsb_p        = 6,
    parameter int hash_en_p         = 0,
    parameter int max_outstanding_p = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    bp_me_bank_steer_if.slave                    io,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o
);
    localparam int lg_lp  = (banks_p > 1) ? $clog2(banks_p) : 1;
    localparam int hb_lp  = paddr_width_p - bank_lsb_p;
    localparam int nch_lp = (hb_lp + lg_lp - 1) / lg_lp;
    localparam int pw_lp  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int cw_lp  = $clog2(max_outstanding_p + 1);

    typedef enum logic {IDLE, BODY} state_e;

    state_e                  r_state;
    logic [lg_lp-1:0]        r_bank;
    logic [lg_lp-1:0]        r_fifo [max_outstanding_p];
    logic [pw_lp-1:0]        r_wptr;
    logic [pw_lp-1:0]        r_rptr;
    logic [cw_lp-1:0]        r_cnt;

    logic [nch_lp*lg_lp-1:0] w_hsrc;
    logic [lg_lp-1:0]        w_hash;
    logic [lg_lp-1:0]        w_idx;
    logic [lg_lp-1:0]        w_sel;
    logic [lg_lp-1:0]        w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_blk;
    logic                    w_cmd_hs;
    logic                    w_push;
    logic                    w_pop;

    function automatic logic [pw_lp-1:0] f_inc(input logic [pw_lp-1:0] p);
        return (p == pw_lp'(max_outstanding_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Upper paddr bits, zero-padded to a whole number of index-sized chunks
    always_comb begin
        w_hsrc = '0;
        w_hsrc[hb_lp-1:0] = io.cmd_header_i[addr_offset_p+bank_lsb_p +: hb_lp];
        w_hash = '0;
        for (int i = 0; i < nch_lp; i++)
            w_hash = w_hash ^ w_hsrc[i*lg_lp +: lg_lp];
    end

    always_comb begin
        w_idx = '0;
        if (banks_p > 1)
            w_idx = (hash_en_p != 0) ? w_hash : w_hsrc[lg_lp-1:0];
    end

    assign w_sel   = (r_state == BODY) ? r_bank : w_idx;
    assign w_full  = (r_cnt == cw_lp'(max_outstanding_p));
    assign w_empty = (r_cnt == '0);
    assign w_blk   = (r_state == IDLE) & w_full;

    assign io.cmd_ready_and_o = reset_n_i & io.bank_cmd_ready_and_i[w_sel] & ~w_blk;
    assign w_cmd_hs = io.cmd_v_i & io.cmd_ready_and_o;
    assign w_push   = w_cmd_hs & (r_state == IDLE);

    always_comb begin
        io.bank_cmd_v_o = '0;
        io.bank_cmd_v_o[w_sel] = reset_n_i & io.cmd_v_i & ~w_blk;
    end

    assign io.bank_cmd_header_o = {banks_p{io.cmd_header_i}};
    assign io.bank_cmd_data_o   = {banks_p{io.cmd_data_i}};
    assign io.bank_cmd_last_o   = {banks_p{io.cmd_last_i}};

    assign w_head = r_fifo[r_rptr];

    assign io.resp_v_o      = reset_n_i & ~w_empty & io.bank_resp_v_i[w_head];
    assign io.resp_header_o = io.bank_resp_header_i[w_head*header_width_p +: header_width_p];
    assign io.resp_data_o   = io.bank_resp_data_i[w_head*data_width_p +: data_width_p];
    assign io.resp_last_o   = io.bank_resp_last_i[w_head];

    // Only the head bank may drain; later banks hold until their turn
    always_comb begin
        io.bank_resp_ready_and_o = '0;
        io.bank_resp_ready_and_o[w_head] = reset_n_i & ~w_empty & io.resp_ready_and_i;
    end

    assign w_pop = io.resp_v_o & io.resp_ready_and_i & io.resp_last_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_bank  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (w_push && !io.cmd_last_i) begin
                    r_bank  <= w_idx;
                    r_state <= BODY;
                end
                BODY: if (w_cmd_hs && io.cmd_last_i)
                    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_push)
                r_wptr <= f_inc(r_wptr);
            if (w_pop)
                r_rptr <= f_inc(r_rptr);
            if (w_push && !w_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_fifo[r_wptr] <= w_idx;
    end

    assign outstanding_o = r_cnt;

`ifndef SYNTHESIS
    logic [header_width_p-1:0] r_hdr;

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_hdr <= io.cmd_header_i;
    end

    a_hdr_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (r_state == BODY && io.cmd_v_i) |-> (io.cmd_header_i == r_hdr));

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        r_cnt <= cw_lp'(max_outstanding_p));
`endif
endmodule

// File: tb/tb_bp_me_bank_steer.sv
// Bench for bp_me_bank_steer: vector table, directed corner sequences,
// and a randomized run against an issue-order scoreboard.
module tb_bp_me_bank_steer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    bp_me_bank_steer_if #(.banks_p(2)) ifa();
    bp_me_bank_steer_if #(.banks_p(4)) ifb();
    logic [3:0] outa;
    logic [1:0] outb;

    bp_me_bank_steer #(.banks_p(2)) u_a (
        .clk_i(clk), .reset_n_i(rst_n), .io(ifa), .outstanding_o(outa)
    );
    bp_me_bank_steer #(.banks_p(4), .hash_en_p(1), .max_outstanding_p(2)) u_b (
        .clk_i(clk), .reset_n_i(rst_n), .io(ifb), .outstanding_o(outb)
    );

    typedef struct {
        bit         on_b;
        logic [39:0] addr;
        logic [3:0] exp_v;
        int         exp_out;
    } vec_t;

    typedef struct {
        int tag;
        int bank;
        int nb;
    } ent_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mkhdr(input logic [39:0] a, input int tag);
        logic [127:0] h;
        h = '0;
        h[39:0] = a;
        h[127:96] = tag;
        return h;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ifa.cmd_header_i = '0; ifa.cmd_data_i = '0;
        ifa.cmd_v_i = 0; ifa.cmd_last_i = 0; ifa.resp_ready_and_i = 0;
        ifa.bank_cmd_ready_and_i = '0; ifa.bank_resp_header_i = '0;
        ifa.bank_resp_data_i = '0; ifa.bank_resp_v_i = '0; ifa.bank_resp_last_i = '0;
        ifb.cmd_header_i = '0; ifb.cmd_data_i = '0;
        ifb.cmd_v_i = 0; ifb.cmd_last_i = 0; ifb.resp_ready_and_i = 0;
        ifb.bank_cmd_ready_and_i = '0; ifb.bank_resp_header_i = '0;
        ifb.bank_resp_data_i = '0; ifb.bank_resp_v_i = '0; ifb.bank_resp_last_i = '0;
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    vec_t vt[10];
    ent_t eq[$];
    int bbeat[2];

    initial begin
        int b;
        logic [5:0] rp;
        int tag, done_tag, msg_on, mbank, mleft, mfirst, hb;
        logic [39:0] maddr;
        logic exp_rdy, blk, rv;

        vt[0] = '{0, 40'h000, 4'b0001, 1};
        vt[1] = '{0, 40'h040, 4'b0010, 2};
        vt[2] = '{0, 40'h080, 4'b0001, 3};
        vt[3] = '{0, 40'h0C0, 4'b0010, 4};
        vt[4] = '{0, 40'h140, 4'b0010, 5};
        vt[5] = '{1, 40'h1C0, 4'b0100, 0};
        vt[6] = '{1, 40'h040, 4'b0010, 0};
        vt[7] = '{1, 40'h100, 4'b0010, 0};
        vt[8] = '{1, 40'h3C0, 4'b0001, 0};
        vt[9] = '{1, 40'h10C0, 4'b0100, 0};

        idle_all();
        #2 rst_n = 0;
        ifa.bank_cmd_ready_and_i = '1;
        ifa.cmd_v_i = 1;
        ifa.resp_ready_and_i = 1;
        ifa.bank_resp_v_i = '1;
        #1;
        chk("rst_out", 64'(outa), 0);
        chk("rst_cmd_rdy", 64'(ifa.cmd_ready_and_o), 0);
        chk("rst_bank_v", 64'(ifa.bank_cmd_v_o), 0);
        chk("rst_resp_v", 64'(ifa.resp_v_o), 0);
        chk("rst_resp_rdy", 64'(ifa.bank_resp_ready_and_o), 0);
        idle_all();
        tick();
        rst_n = 1;
        tick();

        for (int i = 0; i < 10; i++) begin
            if (!vt[i].on_b) begin
                ifa.bank_cmd_ready_and_i = '1;
                ifa.cmd_header_i = mkhdr(vt[i].addr, i);
                ifa.cmd_v_i = 1;
                ifa.cmd_last_i = 1;
                #1;
                chk("tab_a_v", 64'(ifa.bank_cmd_v_o), 64'(vt[i].exp_v));
                chk("tab_a_rdy", 64'(ifa.cmd_ready_and_o), 1);
                tick();
                chk("tab_a_out", 64'(outa), 64'(vt[i].exp_out));
                ifa.cmd_v_i = 0;
            end else begin
                ifb.bank_cmd_ready_and_i = '0;
                ifb.cmd_header_i = mkhdr(vt[i].addr, i);
                ifb.cmd_v_i = 1;
                ifb.cmd_last_i = 1;
                #1;
                chk("tab_b_v", 64'(ifb.bank_cmd_v_o), 64'(vt[i].exp_v));
                chk("tab_b_rdy", 64'(ifb.cmd_ready_and_o), 0);
                tick();
                ifb.cmd_v_i = 0;
                chk("tab_b_out", 64'(outb), 0);
            end
        end
        do_reset();

        // 4-beat message with bank 1 stalling mid-message
        rp = 6'b110011;
        b = 0;
        ifa.cmd_header_i = mkhdr(40'h040, 1);
        for (int c = 0; c < 6; c++) begin
            ifa.bank_cmd_ready_and_i = {rp[c], 1'b1};
            ifa.cmd_v_i = 1;
            ifa.cmd_last_i = (b == 3);
            ifa.cmd_data_i = 64'(b);
            #1;
            chk("mb_v", 64'(ifa.bank_cmd_v_o), 2'b10);
            chk("mb_rdy", 64'(ifa.cmd_ready_and_o), 64'(rp[c]));
            if (rp[c]) b++;
            tick();
        end
        ifa.cmd_v_i = 0;
        chk("mb_beats", 64'(b), 4);
        chk("mb_out", 64'(outa), 1);
        ifa.cmd_header_i = mkhdr(40'h000, 2);
        ifa.cmd_v_i = 1;
        ifa.cmd_last_i = 1;
        #1;
        chk("mb_idle_v", 64'(ifa.bank_cmd_v_o), 2'b01);
        ifa.cmd_v_i = 0;
        do_reset();

        // response ordering: bank 1 answers before bank 0
        ifa.bank_cmd_ready_and_i = '1;
        ifa.cmd_v_i = 1;
        ifa.cmd_last_i = 1;
        ifa.cmd_header_i = mkhdr(40'h000, 10);
        tick();
        ifa.cmd_header_i = mkhdr(40'h040, 11);
        tick();
        ifa.cmd_v_i = 0;
        chk("ord_out2", 64'(outa), 2);
        ifa.resp_ready_and_i = 1;
        ifa.bank_resp_v_i = 2'b10;
        ifa.bank_resp_last_i = 2'b10;
        ifa.bank_resp_header_i[255:128] = mkhdr(40'h0, 11);
        ifa.bank_resp_data_i[127:64] = 64'hB1;
        #1;
        chk("ord_hold_v", 64'(ifa.resp_v_o), 0);
        chk("ord_hold_rdy", 64'(ifa.bank_resp_ready_and_o), 2'b01);
        tick();
        ifa.bank_resp_v_i = 2'b11;
        ifa.bank_resp_last_i = 2'b10;
        ifa.bank_resp_header_i[127:0] = mkhdr(40'h0, 10);
        ifa.bank_resp_data_i[63:0] = 64'hA0;
        #1;
        chk("ord_b0_v", 64'(ifa.resp_v_o), 1);
        chk("ord_b0_d0", ifa.resp_data_o, 64'hA0);
        chk("ord_b0_rdy", 64'(ifa.bank_resp_ready_and_o), 2'b01);
        tick();
        ifa.bank_resp_last_i = 2'b11;
        ifa.bank_resp_data_i[63:0] = 64'hA1;
        #1;
        chk("ord_b0_d1", ifa.resp_data_o, 64'hA1);
        chk("ord_b0_last", 64'(ifa.resp_last_o), 1);
        tick();
        ifa.bank_resp_v_i = 2'b10;
        #1;
        chk("ord_out1", 64'(outa), 1);
        chk("ord_b1_v", 64'(ifa.resp_v_o), 1);
        chk("ord_b1_tag", 64'(ifa.resp_header_o[127:96]), 11);
        chk("ord_b1_d", ifa.resp_data_o, 64'hB1);
        chk("ord_b1_rdy", 64'(ifa.bank_resp_ready_and_o), 2'b10);
        tick();
        ifa.bank_resp_v_i = 2'b01;
        #1;
        chk("ord_out0", 64'(outa), 0);
        chk("stray_v", 64'(ifa.resp_v_o), 0);
        chk("stray_rdy", 64'(ifa.bank_resp_ready_and_o), 0);
        do_reset();

        // full order FIFO (depth 2), pop and new first beat together
        ifb.bank_cmd_ready_and_i = '1;
        ifb.cmd_v_i = 1;
        ifb.cmd_last_i = 1;
        ifb.cmd_header_i = mkhdr(40'h000, 20);
        tick();
        tick();
        chk("full_out", 64'(outb), 2);
        #1;
        chk("full_rdy", 64'(ifb.cmd_ready_and_o), 0);
        chk("full_v", 64'(ifb.bank_cmd_v_o), 0);
        tick();
        ifb.resp_ready_and_i = 1;
        ifb.bank_resp_v_i = 4'b0001;
        ifb.bank_resp_last_i = 4'b0001;
        #1;
        chk("full_pop_v", 64'(ifb.resp_v_o), 1);
        chk("full_pop_rdy", 64'(ifb.cmd_ready_and_o), 0);
        tick();
        ifb.bank_resp_v_i = '0;
        #1;
        chk("full_after_out", 64'(outb), 1);
        chk("full_after_rdy", 64'(ifb.cmd_ready_and_o), 1);
        tick();
        ifb.cmd_v_i = 0;
        chk("full_refill", 64'(outb), 2);
        do_reset();

        // reset during beat 2 of a 4-beat message
        ifa.bank_cmd_ready_and_i = '1;
        ifa.cmd_header_i = mkhdr(40'h040, 30);
        ifa.cmd_v_i = 1;
        ifa.cmd_last_i = 0;
        tick();
        tick();
        #1;
        chk("mr_v_pre", 64'(ifa.bank_cmd_v_o), 2'b10);
        rst_n = 0;
        #1;
        chk("mr_v", 64'(ifa.bank_cmd_v_o), 0);
        chk("mr_rdy", 64'(ifa.cmd_ready_and_o), 0);
        chk("mr_out", 64'(outa), 0);
        tick();
        rst_n = 1;
        ifa.cmd_header_i = mkhdr(40'h000, 31);
        ifa.cmd_last_i = 1;
        #1;
        chk("mr_new_v", 64'(ifa.bank_cmd_v_o), 2'b01);
        chk("mr_new_rdy", 64'(ifa.cmd_ready_and_o), 1);
        tick();
        ifa.cmd_v_i = 0;
        chk("mr_new_out", 64'(outa), 1);
        do_reset();

        // randomized traffic against an issue-order scoreboard
        tag = 100;
        done_tag = 100;
        msg_on = 0;
        mbank = 0;
        mleft = 0;
        mfirst = 0;
        maddr = '0;
        bbeat[0] = 0;
        bbeat[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!msg_on && $urandom_range(0, 3) != 0) begin
                msg_on = 1;
                tag++;
                maddr = 40'($urandom);
                mbank = int'(maddr[6]);
                mleft = $urandom_range(1, 4);
                mfirst = 1;
            end
            ifa.cmd_v_i = msg_on != 0 && $urandom_range(0, 3) != 0;
            ifa.cmd_header_i = mkhdr(maddr, tag);
            ifa.cmd_last_i = (mleft == 1);
            ifa.cmd_data_i = 64'($urandom);
            ifa.bank_cmd_ready_and_i = 2'($urandom);
            ifa.resp_ready_and_i = $urandom_range(0, 2) != 0;
            for (int bk = 0; bk < 2; bk++) begin
                int k;
                k = -1;
                for (int j = 0; j < eq.size(); j++)
                    if (k < 0 && eq[j].bank == bk) k = j;
                ifa.bank_resp_v_i[bk] = 0;
                ifa.bank_resp_last_i[bk] = 0;
                if (k >= 0) begin
                    if (eq[k].tag <= done_tag) begin
                        ifa.bank_resp_v_i[bk] = 1'($urandom_range(0, 1));
                        ifa.bank_resp_header_i[bk*128 +: 128] = mkhdr(40'h0, eq[k].tag);
                        ifa.bank_resp_data_i[bk*64 +: 64] = 64'(eq[k].tag * 256 + bbeat[bk]);
                        ifa.bank_resp_last_i[bk] = (bbeat[bk] == eq[k].nb - 1);
                    end
                end else begin
                    ifa.bank_resp_v_i[bk] = ($urandom_range(0, 3) == 0);
                    ifa.bank_resp_header_i[bk*128 +: 128] = '0;
                    ifa.bank_resp_last_i[bk] = 1;
                end
            end
            #1;
            blk = (mfirst != 0) && (eq.size() == 8);
            exp_rdy = !blk && ifa.bank_cmd_ready_and_i[mbank];
            if (ifa.cmd_v_i) begin
                chk("rnd_bank_v", 64'(ifa.bank_cmd_v_o), blk ? 64'd0 : (64'd1 << mbank));
                chk("rnd_cmd_rdy", 64'(ifa.cmd_ready_and_o), 64'(exp_rdy));
            end else begin
                chk("rnd_bank_v0", 64'(ifa.bank_cmd_v_o), 0);
            end
            chk("rnd_out", 64'(outa), 64'(eq.size()));
            rv = 0;
            hb = 0;
            if (eq.size() == 0) begin
                chk("rnd_resp_v0", 64'(ifa.resp_v_o), 0);
                chk("rnd_resp_rdy0", 64'(ifa.bank_resp_ready_and_o), 0);
            end else begin
                hb = eq[0].bank;
                rv = ifa.bank_resp_v_i[hb];
                chk("rnd_resp_v", 64'(ifa.resp_v_o), 64'(rv));
                chk("rnd_resp_rdy", 64'(ifa.bank_resp_ready_and_o),
                    64'(ifa.resp_ready_and_i) << hb);
                if (rv) begin
                    chk("rnd_resp_tag", 64'(ifa.resp_header_o[127:96]), 64'(eq[0].tag));
                    chk("rnd_resp_data", ifa.resp_data_o, 64'(eq[0].tag * 256 + bbeat[hb]));
                    chk("rnd_resp_last", 64'(ifa.resp_last_o),
                        64'(bbeat[hb] == eq[0].nb - 1));
                end
            end
            if (rv && ifa.resp_ready_and_i) begin
                if (bbeat[hb] == eq[0].nb - 1) begin
                    void'(eq.pop_front());
                    bbeat[hb] = 0;
                end else begin
                    bbeat[hb]++;
                end
            end
            if (ifa.cmd_v_i && exp_rdy) begin
                if (mfirst != 0) begin
                    eq.push_back('{tag, mbank, 1 + tag % 3});
                    mfirst = 0;
                end
                mleft--;
                if (mleft == 0) begin
                    msg_on = 0;
                    done_tag = tag;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
